// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared enums and default sizes for the Montgomery exponentiation sequencer
package mont_pkg;
    localparam int WIDTH_DEF  = 1024;
    localparam int ELEN_W_DEF = 11;

    typedef enum logic [1:0] {
        PH_TOMONT,
        PH_SQR,
        PH_MUL,
        PH_FROMMONT
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;
endpackage

// File: rtl/mont_exp_opmux.sv
// rtl/mont_exp_opmux.sv - registered phase-to-operand selector feeding the Montgomery multiplier
// Loaded with next-cycle values so operands are already valid in the ISSUE cycle.
module mont_exp_opmux
    import mont_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  phase_e           phase_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] xt_i,
    input  logic [WIDTH-1:0] r2_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] mul_a_o,
    output logic [WIDTH-1:0] mul_b_o,
    output logic [WIDTH-1:0] mul_m_o
);
    logic [WIDTH-1:0] a_q, b_q, m_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            m_q <= '0;
        end else if (load_i) begin
            m_q <= m_i;
            case (phase_i)
                PH_TOMONT: begin a_q <= x_i; b_q <= r2_i; end
                PH_SQR:    begin a_q <= acc_i; b_q <= acc_i; end
                PH_MUL:    begin a_q <= acc_i; b_q <= xt_i; end
                default:   begin a_q <= acc_i; b_q <= WIDTH'(1); end
            endcase
        end
    end

    assign mul_a_o = a_q;
    assign mul_b_o = b_q;
    assign mul_m_o = m_q;
endmodule

// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right square-and-multiply sequencer around one shared Montgomery multiplier
// Optional MONT_EXP_PERF_CNT_EN adds the 32-bit perf_cycles run-length counter.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ELEN_W = ELEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_e,
    input  logic [ELEN_W-1:0] in_e_len,
    input  logic [WIDTH-1:0]  in_m,
    input  logic [WIDTH-1:0]  in_r2,
    input  logic [WIDTH-1:0]  in_rmodm,
    output logic [WIDTH-1:0]  result,
    output logic              done,
    output logic              busy,
    output logic              mul_start,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    output logic [WIDTH-1:0]  mul_m,
    input  logic [WIDTH-1:0]  mul_result,
    input  logic              mul_done
`ifdef MONT_EXP_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);
    localparam int IDX_W = $clog2(WIDTH);

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [WIDTH-1:0]  x_q, x_d, e_q, e_d, m_q, m_d, r2_q, r2_d;
    logic [WIDTH-1:0]  xt_q, xt_d, acc_q, acc_d, result_q, result_d;
    logic [ELEN_W-1:0] elen_q, elen_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, busy_q, mul_start_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        x_d      = x_q;
        e_d      = e_q;
        m_d      = m_q;
        r2_d     = r2_q;
        xt_d     = xt_q;
        acc_d    = acc_q;
        result_d = result_q;
        elen_d   = elen_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE: if (start) begin
                x_d     = in_x;
                e_d     = in_e;
                m_d     = in_m;
                r2_d    = in_r2;
                acc_d   = in_rmodm;
                elen_d  = (in_e_len > ELEN_W'(WIDTH)) ? ELEN_W'(WIDTH) : in_e_len;
                phase_d = PH_TOMONT;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: if (mul_done) begin
                state_d = ST_ISSUE;
                case (phase_q)
                    PH_TOMONT: begin
                        xt_d = mul_result;
                        if (elen_q == '0) begin
                            phase_d = PH_FROMMONT;
                        end else begin
                            idx_d   = IDX_W'(elen_q - ELEN_W'(1));
                            phase_d = PH_SQR;
                        end
                    end
                    PH_SQR: begin
                        acc_d = mul_result;
                        if (e_q[idx_q])          phase_d = PH_MUL;
                        else if (idx_q == '0)    phase_d = PH_FROMMONT;
                        else                     idx_d   = idx_q - IDX_W'(1);
                    end
                    PH_MUL: begin
                        acc_d = mul_result;
                        if (idx_q == '0) begin
                            phase_d = PH_FROMMONT;
                        end else begin
                            idx_d   = idx_q - IDX_W'(1);
                            phase_d = PH_SQR;
                        end
                    end
                    default: begin
                        result_d = mul_result;
                        state_d  = ST_DONE;
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_TOMONT;
            x_q         <= '0;
            e_q         <= '0;
            m_q         <= '0;
            r2_q        <= '0;
            xt_q        <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            elen_q      <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            x_q         <= x_d;
            e_q         <= e_d;
            m_q         <= m_d;
            r2_q        <= r2_d;
            xt_q        <= xt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            elen_q      <= elen_d;
            idx_q       <= idx_d;
            done_q      <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
            mul_start_q <= (state_d == ST_ISSUE);
        end
    end

    mont_exp_opmux #(.WIDTH(WIDTH)) u_opmux (
        .clk     (clk),
        .reset   (reset),
        .load_i  (state_d == ST_ISSUE),
        .phase_i (phase_d),
        .acc_i   (acc_d),
        .x_i     (x_d),
        .xt_i    (xt_d),
        .r2_i    (r2_d),
        .m_i     (m_d),
        .mul_a_o (mul_a),
        .mul_b_o (mul_b),
        .mul_m_o (mul_m)
    );

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;

`ifdef MONT_EXP_PERF_CNT_EN
    logic [31:0] perf_q;

    // The accepting cycle counts as the first, so the value equals start-to-done latency.
    always_ff @(posedge clk) begin
        if (reset)                                   perf_q <= '0;
        else if (state_q == ST_IDLE && start)        perf_q <= 32'd1;
        else if (state_q != ST_IDLE && perf_q != '1) perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - self-checking bench for mont_exp_ctrl with a behavioural Montgomery multiplier
module tb_mont_exp_ctrl;
    localparam int W  = 1024;
    localparam int EL = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic [W-1:0]  in_x, in_e, in_m, in_r2, in_rmodm;
    logic [EL-1:0] in_e_len;
    logic [W-1:0]  result, mul_a, mul_b, mul_m, mul_result;
    logic          done, busy, mul_start, mul_done, done_model, done_spur;
`ifdef MONT_EXP_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    assign mul_done = done_model | done_spur;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;

    mont_exp_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_x       (in_x),
        .in_e       (in_e),
        .in_e_len   (in_e_len),
        .in_m       (in_m),
        .in_r2      (in_r2),
        .in_rmodm   (in_rmodm),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_m      (mul_m),
        .mul_result (mul_result),
        .mul_done   (mul_done)
`ifdef MONT_EXP_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed lo128=%0h expected lo128=%0h", tag, obs[127:0], expv[127:0]);
        end
    endtask

    // a*b*2^-W mod m, bit-serial reduction
    function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] r_mod(input logic [W-1:0] m);
        logic [2*W-1:0] big;
        big    = '0;
        big[W] = 1'b1;
        return W'(big % {{W{1'b0}}, m});
    endfunction

    function automatic logic [W-1:0] r2_mod(input logic [W-1:0] m);
        logic [2*W-1:0] rm;
        rm = {{W{1'b0}}, r_mod(m)};
        return W'((rm * rm) % {{W{1'b0}}, m});
    endfunction

    function automatic logic [W-1:0] ref_exp(input logic [W-1:0] x, input logic [W-1:0] e,
                                             input logic [W-1:0] m, input int t);
        logic [2*W-1:0] r, mw, xw;
        mw   = {{W{1'b0}}, m};
        xw   = {{W{1'b0}}, x};
        r    = '0;
        r[0] = 1'b1;
        for (int i = t - 1; i >= 0; i--) begin
            r = (r * r) % mw;
            if (e[i]) r = (r * xw) % mw;
        end
        r = r % mw;
        return W'(r);
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [W-1:0] ma, mb, mm;
    bit           aborted;

    initial begin
        done_model = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            if (mul_start === 1'b1 && reset === 1'b0) begin
                ma = mul_a;
                mb = mul_b;
                mm = mul_m;
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    #1;
                    check("opnd_stable", (mul_a ^ ma) | (mul_b ^ mb) | (mul_m ^ mm), '0);
                    mul_result = mont_mul(ma, mb, mm);
                    done_model = 1'b1;
                    @(posedge clk);
                    #1 done_model = 1'b0;
                end
            end
        end
    end

    task automatic drive_inputs(input logic [W-1:0] x, input logic [W-1:0] e,
                                input logic [EL-1:0] elen, input logic [W-1:0] m);
        in_x     = x;
        in_e     = e;
        in_e_len = elen;
        in_m     = m;
        in_rmodm = r_mod(m);
        in_r2    = r2_mod(m);
    endtask

    task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] e,
                       input logic [EL-1:0] elen, input logic [W-1:0] m, input int l, input bit spam);
        logic [W-1:0] expv, res_at_done;
        int t, n, cyc, starts;
        bit seen, busy_at_done;
        t = (int'(elen) > W) ? W : int'(elen);
        n = 2 + t;
        for (int i = 0; i < t; i++) if (e[i]) n++;
        expv = ref_exp(x, e, m, t);
        lat  = l;
        @(negedge clk);
        drive_inputs(x, e, elen, m);
        start = 1'b1;
        @(posedge clk);
        cyc = 0; starts = 0; seen = 1'b0; busy_at_done = 1'b1;
        while (!seen && cyc < n * (l + 1) + 20) begin
            @(negedge clk);
            cyc++;
            if (mul_start === 1'b1) starts++;
            if (done === 1'b1) begin
                seen = 1'b1;
                busy_at_done = busy;
            end
            if (!spam || seen) start = 1'b0;
        end
        start = 1'b0;
        res_at_done = result;
        check({tag, "_finished"}, W'(seen), W'(1));
        check({tag, "_result"}, result, expv);
        check({tag, "_mul_count"}, W'(starts), W'(n));
        // edges from the accepting edge up to the edge that samples done
        check({tag, "_latency"}, W'(cyc + 1), W'(n * (l + 1) + 2));
        check({tag, "_busy_low_at_done"}, W'(busy_at_done), '0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, W'(done), '0);
        check({tag, "_result_hold"}, result, res_at_done);
    endtask

    logic [W-1:0] rx, re, rm_;

    initial begin
        reset = 1'b1; start = 1'b0; done_spur = 1'b0;
        drive_inputs('0, '0, '0, W'(13));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, '0);
        check("rst_done", W'(done), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_mul_start", W'(mul_start), '0);
        check("rst_mul_ops", mul_a | mul_b | mul_m, '0);
        reset = 1'b0;

        run("A", W'(5), W'(3), EL'(2), W'(13), 4, 1'b0);
        check("A_const8", result, W'(8));
`ifdef MONT_EXP_PERF_CNT_EN
        check("A_perf", W'(perf_cycles), W'(32));
        repeat (3) @(negedge clk);
        check("A_perf_hold", W'(perf_cycles), W'(32));
`endif

        run("B", W'(7), W'(0), EL'(0), W'(13), 3, 1'b0);
        check("B_const1", result, W'(1));

        // stray multiplier completion while idle must not start or disturb anything
        @(negedge clk);
        done_spur = 1'b1;
        @(negedge clk);
        done_spur = 1'b0;
        check("spur_busy", W'(busy), '0);
        check("spur_mul_start", W'(mul_start), '0);
        check("spur_result", result, W'(1));
        @(negedge clk);
        check("spur_busy2", W'(busy), '0);

        rm_ = rand_w(); rm_[0] = 1'b1; rm_[W-1] = 1'b1;
        rx = rand_w(); if (rx >= rm_) rx = rx - rm_;
        run("spam", rx, rand_w(), EL'(20), rm_, 2, 1'b1);

        // reset while the controller waits on the multiplier
        @(negedge clk);
        drive_inputs(W'(9), W'(1000), EL'(10), W'(13));
        lat = 6;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rstw_busy_before", W'(busy), W'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstw_busy", W'(busy), '0);
        check("rstw_done", W'(done), '0);
        check("rstw_mul_start", W'(mul_start), '0);
        check("rstw_result", result, '0);
        reset = 1'b0;
        run("after_rst", W'(9), W'(1000), EL'(10), W'(13), 3, 1'b0);

        run("big", W'(2), {W{1'b1}}, EL'(1024), {W{1'b1}} - W'(104), 2, 1'b0);

        rm_ = rand_w(); rm_[0] = 1'b1; rm_[W-1] = 1'b1;
        rx = rand_w(); if (rx >= rm_) rx = rx - rm_;
        run("sat", rx, rand_w(), EL'(2000), rm_, 1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rm_ = rand_w(); rm_[0] = 1'b1; rm_[W-1] = 1'b1;
            rx = rand_w(); if (rx >= rm_) rx = rx - rm_;
            re = rand_w();
            run($sformatf("rnd%0d", r), rx, re, EL'($urandom_range(0, 48)), rm_,
                int'($urandom_range(1, 5)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mont_exp_ctrl.md
# mont_exp_ctrl

Sequencer for modular exponentiation (result = X^E mod M) using left-to-right binary square-and-multiply. It shares one 1024-bit Montgomery multiplier (a multi-cycle core with a start/done handshake) across all steps. It converts into the Montgomery domain, runs the square and multiply steps, and converts back out. It sits between the RSA top-level register interface and the multiplier, and is the only driver of the multiplier's operand and start inputs.

## Interface
Parameters:
- WIDTH, 1024, operand and modulus width in bits.
- ELEN_W, 11, width of the exponent-length field (range 0..1024).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- in_x  in  WIDTH  base X, with X < M.
- in_e  in  WIDTH  exponent E.
- in_e_len  in  ELEN_W  number of significant exponent bits t; bits of E at index t and above are ignored.
- in_m  in  WIDTH  odd modulus M.
- in_r2  in  WIDTH  R² mod M, where R = 2^WIDTH.
- in_rmodm  in  WIDTH  R mod M.
- result  out  WIDTH  X^E mod M; reset value 0.
- done  out  1  one-cycle pulse when result is valid; reset value 0.
- busy  out  1  high from the cycle after start is accepted until done; reset value 0.
- mul_start  out  1  one-cycle start pulse to the multiplier; reset value 0.
- mul_a, mul_b, mul_m  out  WIDTH each  multiplier operands; reset value 0.
- mul_result  in  WIDTH  multiplier output.
- mul_done  in  1  multiplier completion pulse.

## Operation
- On an accepted start, capture in_x, in_e, in_e_len, in_m, in_r2 and in_rmodm into internal registers. Load accumulator A ← in_rmodm, set phase = TOMONT, then enter ISSUE.
- Main states:
  - IDLE.
  - ISSUE: mul_start = 1 for exactly one cycle.
  - WAIT: hold until mul_done.
  - DONE: done = 1 for one cycle, then return to IDLE.
- Phase register selects the multiplier operands:
  - TOMONT: a = X, b = R2.
  - SQR: a = A, b = A.
  - MUL: a = A, b = X~.
  - FROMMONT: a = A, b = 1.
  - mul_m is always the captured M.
- mul_a, mul_b and mul_m are registered. They are stable from the ISSUE cycle through the cycle mul_done is seen, because the multiplier samples in_b and in_m every cycle of its run.
- Decision on mul_done in WAIT; capture mul_result in the same edge:
  - TOMONT: X~ ← mul_result. If t = 0 go to FROMMONT; else i ← t−1 and go to SQR.
  - SQR: A ← mul_result. If E[i] = 1 go to MUL. Else if i = 0 go to FROMMONT. Else i ← i−1 and go to SQR.
  - MUL: A ← mul_result. If i = 0 go to FROMMONT; else i ← i−1 and go to SQR.
  - FROMMONT: result ← mul_result, then go to DONE.
- Multiplications per run = 2 + t + popcount(E[t−1:0]).
- Boundary behaviour:
  - t = 0 gives result = 1 (R mod M converted out).
  - in_e_len > 1024 saturates to 1024.
  - start while busy is ignored.
  - mul_done outside WAIT is ignored.
  - result holds its value until the next FROMMONT capture.
- reset mid-run: return to IDLE next edge and drive all outputs to their reset values. The multiplier must be reset by the same top-level reset, so no in-flight done is later misattributed.

## Timing
- Start accepted at edge 0 → busy = 1 and state ISSUE from cycle 1 → mul_start high in cycle 1.
- mul_done sampled in cycle k → next ISSUE (mul_start) in cycle k+1. This gives 1 cycle of controller overhead per multiplication plus the multiplier latency L.
- Total latency from start to done = N·(L+1) + 2, where N is the multiplication count.
- done is high in the cycle after the final mul_done, and busy falls in that same cycle.
- A new start is accepted in the cycle after done.

## Configuration
- MONT_EXP_PERF_CNT_EN:
  - Defined: adds output perf_cycles (32 bits, reset 0). It clears on an accepted start, increments every busy cycle, saturates at 0xFFFFFFFF, and holds after done.
  - Undefined: no port and no counter logic.

## Structure
- Shared package mont_pkg holds:
  - the phase enum (TOMONT, SQR, MUL, FROMMONT);
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - constants WIDTH_DEF = 1024 and ELEN_W_DEF = 11.
- One natural sub-module: mont_exp_opmux. It is the registered operand selector (phase → mul_a/mul_b), kept separate for timing on the 1024-bit muxes. FSM and index counter stay in mont_exp_ctrl.
- The bench uses a behavioural multiplier model returning a·b·R⁻¹ mod m after a programmable latency L.

## Test plan
- M = 13, X = 5, E = 3, t = 2, L = 4 → result = 8. Exactly 6 mul_start pulses. done at cycle 6·5+2 = 32 after start.
- M = 13, X = 7, E = 0, t = 0 → result = 1 after 2 multiplications (TOMONT, FROMMONT).
- M = 2^1024−105 (odd), X = 2, E = 2^1024−1, t = 1024 → matches the reference model. 2050 multiplications.
- start pulsed every cycle during a run → only the first is accepted. result matches a single run. No extra mul_start.
- reset asserted while in WAIT:
  - next cycle: busy = 0, done = 0, mul_start = 0, result = 0;
  - a fresh start afterwards completes correctly.
- With MONT_EXP_PERF_CNT_EN defined, first scenario → perf_cycles = 32 after done, holding until next start.
